msg_bus_arbiter: RTL and testbench

Shares the single message-bus send port among `N_PORTS` requesters, typically the per-hart xctcmsg instances of a cluster, each exposing its val/ack/dst/tag/msg send interface. Grants are round-robin and work-conserving. The granted message is registered and held on the bus until acknowledged, and the local address of the granted port is presented as the message source. It sits between the hart-side send interfaces and the shared interconnect and keeps a wrap-around count of delivered messages.

---
 rtl/msg_bus_arbiter_if.sv | 32 +++
 rtl/msg_bus_arbiter.sv | 97 +++++++++
 tb/tb_msg_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msg_bus_arbiter_if.sv
// Send-side and interconnect-side signals of the message-bus arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface msg_bus_arbiter_if #(
  parameter int unsigned N_PORTS = 4
);
  logic [N_PORTS-1:0]    req_val_i;
  logic [N_PORTS-1:0]    req_ack_o;
  logic [N_PORTS*32-1:0] req_dst_i;
  logic [N_PORTS*32-1:0] req_tag_i;
  logic [N_PORTS*64-1:0] req_msg_i;
  logic [N_PORTS*32-1:0] port_address_i;
  logic                  bus_val_o;
  logic                  bus_ack_i;
  logic [31:0]           bus_src_o;
  logic [31:0]           bus_dst_o;
  logic [31:0]           bus_tag_o;
  logic [63:0]           bus_msg_o;
  logic [N_PORTS-1:0]    grant_o;
  logic [31:0]           sent_count_o;

  modport slave (
    input  req_val_i, req_dst_i, req_tag_i, req_msg_i, port_address_i, bus_ack_i,
    output req_ack_o, bus_val_o, bus_src_o, bus_dst_o, bus_tag_o, bus_msg_o, grant_o,
           sent_count_o
  );

  modport master (
    output req_val_i, req_dst_i, req_tag_i, req_msg_i, port_address_i, bus_ack_i,
    input  req_ack_o, bus_val_o, bus_src_o, bus_dst_o, bus_tag_o, bus_msg_o, grant_o,
           sent_count_o
  );
endinterface

// File: rtl/msg_bus_arbiter.sv
// Round-robin, work-conserving arbiter sharing one message-bus send port among N_PORTS
// requesters; the granted message is registered and held until the bus acknowledges it.
module msg_bus_arbiter #(
  parameter int unsigned N_PORTS = 4
) (
  input logic              clk,
  input logic              rst_n,
  msg_bus_arbiter_if.slave mb
);
  localparam int unsigned IdxW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    last_q, last_d, pick, scan;
  logic [N_PORTS-1:0] grant_q, grant_d, eligible;
  logic [31:0]        src_q, src_d, dst_q, dst_d, tag_q, tag_d, cnt_q, cnt_d;
  logic [63:0]        msg_q, msg_d;
  logic               ack_fire, found, load;

  assign ack_fire = (state_q == StSend) && mb.bus_ack_i;
  // The just-acked port still shows val this cycle, so it must not win again.
  assign eligible = mb.req_val_i & ~({N_PORTS{ack_fire}} & grant_q);

  always_comb begin
    found = 1'b0;
    pick  = last_q;
    scan  = last_q;
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      scan = IdxW'((32'(last_q) + k) % N_PORTS);
      if (!found && eligible[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    src_d   = src_q;
    dst_d   = dst_q;
    tag_d   = tag_q;
    msg_d   = msg_q;
    cnt_d   = cnt_q;
    load    = found && ((state_q == StIdle) || ack_fire);

    if (ack_fire) begin
      cnt_d   = cnt_q + 32'd1;
      state_d = StIdle;
      grant_d = '0;
    end

    if (load) begin
      state_d       = StSend;
      last_d        = pick;
      grant_d       = '0;
      grant_d[pick] = 1'b1;
      src_d         = mb.port_address_i[32'(pick) * 32 +: 32];
      dst_d         = mb.req_dst_i[32'(pick) * 32 +: 32];
      tag_d         = mb.req_tag_i[32'(pick) * 32 +: 32];
      msg_d         = mb.req_msg_i[32'(pick) * 64 +: 64];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= IdxW'(N_PORTS - 1);
      grant_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      tag_q   <= '0;
      msg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      tag_q   <= tag_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mb.bus_val_o    = (state_q == StSend);
  assign mb.req_ack_o    = {N_PORTS{ack_fire}} & grant_q;
  assign mb.grant_o      = grant_q;
  assign mb.bus_src_o    = src_q;
  assign mb.bus_dst_o    = dst_q;
  assign mb.bus_tag_o    = tag_q;
  assign mb.bus_msg_o    = msg_q;
  assign mb.sent_count_o = cnt_q;
endmodule

// File: tb/tb_msg_bus_arbiter.sv
// Bench for msg_bus_arbiter: table vectors, directed corner sequences, and a randomized
// run checked against a transaction-level reference model.
module tb_msg_bus_arbiter;
  localparam int unsigned NP = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  msg_bus_arbiter_if #(.N_PORTS(NP)) mb ();

  msg_bus_arbiter #(.N_PORTS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mb    (mb)
  );

  logic [31:0] dst [NP];
  logic [31:0] tag [NP];
  logic [31:0] addr[NP];
  logic [63:0] msg [NP];

  always_comb begin
    mb.req_dst_i      = '0;
    mb.req_tag_i      = '0;
    mb.req_msg_i      = '0;
    mb.port_address_i = '0;
    for (int i = 0; i < NP; i++) begin
      mb.req_dst_i[32*i +: 32]      = dst[i];
      mb.req_tag_i[32*i +: 32]      = tag[i];
      mb.req_msg_i[64*i +: 64]      = msg[i];
      mb.port_address_i[32*i +: 32] = addr[i];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and settle before checking.
  task automatic cyc(input logic [NP-1:0] v, input logic a);
    @(negedge clk);
    mb.req_val_i = v;
    mb.bus_ack_i = a;
    #1;
  endtask

  task automatic chk_zero(input string tagname);
    chk({tagname, "_val"},   64'(mb.bus_val_o), 64'd0);
    chk({tagname, "_grant"}, 64'(mb.grant_o), 64'd0);
    chk({tagname, "_ack"},   64'(mb.req_ack_o), 64'd0);
    chk({tagname, "_src"},   64'(mb.bus_src_o), 64'd0);
    chk({tagname, "_dst"},   64'(mb.bus_dst_o), 64'd0);
    chk({tagname, "_tag"},   64'(mb.bus_tag_o), 64'd0);
    chk({tagname, "_msg"},   mb.bus_msg_o, 64'd0);
    chk({tagname, "_cnt"},   64'(mb.sent_count_o), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    mb.req_val_i = '0;
    mb.bus_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_zero("reset");
  endtask

  task automatic set_default_data();
    for (int i = 0; i < NP; i++) begin
      dst[i]  = 32'h1000 + 32'(i);
      tag[i]  = 32'h20 + 32'(i);
      msg[i]  = 64'hA0 + 64'(i);
      addr[i] = 32'(i + 1);
    end
  endtask

  typedef struct {
    logic [NP-1:0] val;
    logic          ack;
    logic          exp_val;
    logic [NP-1:0] exp_grant;
    logic [NP-1:0] exp_ack;
    logic [31:0]   exp_cnt;
  } vec_t;

  task automatic run_table();
    vec_t tbl[18];
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 4'h0, 4'h0, 32'd0};
    tbl[1]  = '{4'hF, 1'b1, 1'b1, 4'h1, 4'h1, 32'd0};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 4'h2, 4'h2, 32'd1};
    tbl[3]  = '{4'hF, 1'b1, 1'b1, 4'h4, 4'h4, 32'd2};
    tbl[4]  = '{4'hF, 1'b1, 1'b1, 4'h8, 4'h8, 32'd3};
    tbl[5]  = '{4'hF, 1'b1, 1'b1, 4'h1, 4'h1, 32'd4};
    tbl[6]  = '{4'hF, 1'b1, 1'b1, 4'h2, 4'h2, 32'd5};
    tbl[7]  = '{4'hF, 1'b1, 1'b1, 4'h4, 4'h4, 32'd6};
    tbl[8]  = '{4'hF, 1'b1, 1'b1, 4'h8, 4'h8, 32'd7};
    tbl[9]  = '{4'h0, 1'b0, 1'b1, 4'h1, 4'h0, 32'd8};
    tbl[10] = '{4'h0, 1'b1, 1'b1, 4'h1, 4'h1, 32'd8};
    tbl[11] = '{4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'd9};
    tbl[12] = '{4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'd9};
    tbl[13] = '{4'h4, 1'b1, 1'b0, 4'h0, 4'h0, 32'd9};
    tbl[14] = '{4'h4, 1'b1, 1'b1, 4'h4, 4'h4, 32'd9};
    tbl[15] = '{4'h4, 1'b1, 1'b0, 4'h0, 4'h0, 32'd10};
    tbl[16] = '{4'h4, 1'b1, 1'b1, 4'h4, 4'h4, 32'd10};
    tbl[17] = '{4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'd11};
    set_default_data();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      cyc(tbl[c].val, tbl[c].ack);
      chk($sformatf("tbl%0d_val", c),   64'(mb.bus_val_o), 64'(tbl[c].exp_val));
      chk($sformatf("tbl%0d_grant", c), 64'(mb.grant_o), 64'(tbl[c].exp_grant));
      chk($sformatf("tbl%0d_ack", c),   64'(mb.req_ack_o), 64'(tbl[c].exp_ack));
      chk($sformatf("tbl%0d_cnt", c),   64'(mb.sent_count_o), 64'(tbl[c].exp_cnt));
      for (int p = 0; p < NP; p++) begin
        if (tbl[c].exp_val && tbl[c].exp_grant[p]) begin
          chk($sformatf("tbl%0d_src", c), 64'(mb.bus_src_o), 64'(addr[p]));
          chk($sformatf("tbl%0d_dst", c), 64'(mb.bus_dst_o), 64'(dst[p]));
        end
      end
    end
  endtask

  task automatic run_directed();
    // Single request, ack held high: one-cycle occupancy.
    set_default_data();
    dst[1] = 32'h10; tag[1] = 32'h5; msg[1] = 64'hDEAD; addr[1] = 32'h2;
    do_reset();
    cyc(4'b0010, 1'b1);
    chk("s1_idle_val", 64'(mb.bus_val_o), 64'd0);
    cyc(4'b0010, 1'b1);
    chk("s1_val",   64'(mb.bus_val_o), 64'd1);
    chk("s1_src",   64'(mb.bus_src_o), 64'h2);
    chk("s1_dst",   64'(mb.bus_dst_o), 64'h10);
    chk("s1_tag",   64'(mb.bus_tag_o), 64'h5);
    chk("s1_msg",   mb.bus_msg_o, 64'hDEAD);
    chk("s1_grant", 64'(mb.grant_o), 64'b0010);
    chk("s1_ack",   64'(mb.req_ack_o), 64'b0010);
    cyc(4'b0000, 1'b1);
    chk("s1_after_val", 64'(mb.bus_val_o), 64'd0);
    chk("s1_after_cnt", 64'(mb.sent_count_o), 64'd1);

    // Stalled bus: held message must ignore requester changes.
    set_default_data();
    msg[2] = 64'h1111;
    do_reset();
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b0);
    chk("stall_grant0", 64'(mb.grant_o), 64'b0100);
    @(posedge clk);
    msg[2] = 64'h2222;
    for (int c = 0; c < 4; c++) begin
      cyc(4'b0101, 1'b0);
      chk($sformatf("stall%0d_msg", c),   mb.bus_msg_o, 64'h1111);
      chk($sformatf("stall%0d_grant", c), 64'(mb.grant_o), 64'b0100);
      chk($sformatf("stall%0d_ack", c),   64'(mb.req_ack_o), 64'd0);
    end
    cyc(4'b0101, 1'b1);
    chk("stall_ack", 64'(mb.req_ack_o), 64'b0100);
    cyc(4'b0001, 1'b0);
    chk("stall_next_grant", 64'(mb.grant_o), 64'b0001);
    chk("stall_next_msg",   mb.bus_msg_o, msg[0]);
    chk("stall_next_cnt",   64'(mb.sent_count_o), 64'd1);

    // Asynchronous reset while a message is held.
    set_default_data();
    do_reset();
    cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b0);
    chk("arst_pre_val", 64'(mb.bus_val_o), 64'd1);
    #2;
    rst_n        = 1'b0;
    mb.bus_ack_i = 1'b1;
    #1;
    chk_zero("arst");
    @(negedge clk);
    rst_n        = 1'b1;
    mb.bus_ack_i = 1'b0;
    cyc(4'b1000, 1'b0);
    chk("arst_post_grant", 64'(mb.grant_o), 64'b1000);
    chk("arst_post_src",   64'(mb.bus_src_o), 64'(addr[3]));
    chk("arst_post_cnt",   64'(mb.sent_count_o), 64'd0);
    cyc(4'b1000, 1'b1);
    chk("arst_post_ack",   64'(mb.req_ack_o), 64'b1000);

    // Counter wrap.
    do_reset();
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.cnt_q;
    #1;
    chk("wrap_pre", 64'(mb.sent_count_o), 64'hFFFF_FFFF);
    cyc(4'b0001, 1'b1);
    cyc(4'b0001, 1'b1);
    chk("wrap_ack", 64'(mb.req_ack_o), 64'b0001);
    cyc(4'b0000, 1'b0);
    chk("wrap_cnt", 64'(mb.sent_count_o), 64'd0);
  endtask

  // Reference model: one held message at a time; a freed bus goes to the next requester
  // after the previous owner in circular order, never to the port acked this cycle.
  task automatic run_random();
    bit          m_busy = 1'b0;
    int          m_owner = 0;
    int          m_last = NP - 1;
    logic [31:0] m_src = '0, m_dst = '0, m_tag = '0, m_cnt = '0;
    logic [63:0] m_msg = '0;
    bit          pend[NP];
    logic [NP-1:0] v;
    logic        a;
    int          excl;
    bit          free;

    for (int i = 0; i < NP; i++) begin
      pend[i] = 1'b0;
      addr[i] = $urandom;
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          dst[i]  = $urandom;
          tag[i]  = $urandom;
          msg[i]  = {$urandom, $urandom};
        end
        v[i] = pend[i];
      end
      a = ($urandom_range(0, 9) < 6);
      mb.req_val_i = v;
      mb.bus_ack_i = a;
      #1;
      chk("rnd_val",   64'(mb.bus_val_o), 64'(m_busy));
      chk("rnd_grant", 64'(mb.grant_o), m_busy ? (64'd1 << m_owner) : 64'd0);
      chk("rnd_ack",   64'(mb.req_ack_o), (m_busy && a) ? (64'd1 << m_owner) : 64'd0);
      chk("rnd_cnt",   64'(mb.sent_count_o), 64'(m_cnt));
      if (m_busy) begin
        chk("rnd_src", 64'(mb.bus_src_o), 64'(m_src));
        chk("rnd_dst", 64'(mb.bus_dst_o), 64'(m_dst));
        chk("rnd_tag", 64'(mb.bus_tag_o), 64'(m_tag));
        chk("rnd_msg", mb.bus_msg_o, m_msg);
      end
      excl = -1;
      free = !m_busy;
      if (m_busy && a) begin
        m_cnt         = m_cnt + 1;
        pend[m_owner] = 1'b0;
        excl          = m_owner;
        m_busy        = 1'b0;
        free          = 1'b1;
      end
      if (free) begin
        for (int k = 1; k <= NP; k++) begin
          int p;
          p = (m_last + k) % NP;
          if (!m_busy && v[p] && p != excl) begin
            m_busy  = 1'b1;
            m_owner = p;
            m_last  = p;
            m_src   = addr[p];
            m_dst   = dst[p];
            m_tag   = tag[p];
            m_msg   = msg[p];
          end
        end
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    mb.req_val_i = '0;
    mb.bus_ack_i = 1'b0;
    set_default_data();
    run_table();
    run_directed();
    run_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
